// File: rtl/bounce_sprite.sv
// Bouncing ball sprite for the VGA pong game: moves one step per divider tick, bounces off
// walls and the paddle, counts misses against a lives budget and drives registered pixel colour.
module bounce_sprite #(
    parameter int CW         = 11,
    parameter int DW         = 5,
    parameter int SCREEN_W   = 800,
    parameter int SCREEN_H   = 600,
    parameter int SIZE_W     = 14,
    parameter int SIZE_H     = 20,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int LIVES      = 3,
    parameter int SERVE_WAIT = 60
) (
    input  logic          CLK_100MHz,
    input  logic          Reset,
    input  logic          tick,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic [DW-1:0] delX,
    input  logic [DW-1:0] delY,
    input  logic [11:0]   rgbIn,
    input  logic          launch,
    input  logic [CW-1:0] padX,
    input  logic [CW-1:0] padY,
    input  logic [CW-1:0] padW,
    input  logic [CW-1:0] padH,
    output logic          yes,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic [CW-1:0] posX,
    output logic [CW-1:0] posY,
    output logic          miss,
    output logic [3:0]    livesLeft,
    output logic          gameOver
);

    localparam int EW    = CW + 1;
    localparam int CNT_W = $clog2(SERVE_WAIT + 1);

    localparam logic [CW-1:0]    START_X_C = CW'(START_X);
    localparam logic [CW-1:0]    START_Y_C = CW'(START_Y);
    localparam logic [EW-1:0]    SCR_W_E   = EW'(SCREEN_W);
    localparam logic [EW-1:0]    SCR_H_E   = EW'(SCREEN_H);
    localparam logic [EW-1:0]    SZ_W_E    = EW'(SIZE_W);
    localparam logic [EW-1:0]    SZ_H_E    = EW'(SIZE_H);
    localparam logic [CW-1:0]    SZ_W_C    = CW'(SIZE_W);
    localparam logic [CW-1:0]    BOTTOM_C  = CW'(SCREEN_H - SIZE_H);
    localparam logic [3:0]       LIVES_C   = 4'(LIVES);
    localparam logic [CNT_W-1:0] WAIT_C    = CNT_W'(SERVE_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE,
        ST_MISS,
        ST_OVER
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    pos_x_reg, pos_x_next;
    logic [CW-1:0]    pos_y_reg, pos_y_next;
    logic             dir_x_neg_reg, dir_x_neg_next;
    logic             dir_y_neg_reg, dir_y_neg_next;
    logic [3:0]       lives_reg, lives_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             yes_reg;
    logic [11:0]      rgb_reg;

    // Everything geometric is compared one bit wider so sums near the screen edge never wrap.
    logic [EW-1:0] px_e, py_e, dx_e, dy_e, nx_e;
    logic [EW-1:0] pad_x_e, pad_y_e, pad_w_e, pad_h_e;
    logic [EW-1:0] raster_x_e, raster_y_e;
    logic          pad_hit;
    logic          pix_hit;
    logic [11:0]   rgb_mask;
    logic [CNT_W-1:0] count_inc;

    assign px_e       = {1'b0, pos_x_reg};
    assign py_e       = {1'b0, pos_y_reg};
    assign dx_e       = EW'(delX);
    assign dy_e       = EW'(delY);
    assign nx_e       = px_e + dx_e;
    assign pad_x_e    = {1'b0, padX};
    assign pad_y_e    = {1'b0, padY};
    assign pad_w_e    = {1'b0, padW};
    assign pad_h_e    = {1'b0, padH};
    assign raster_x_e = {1'b0, X};
    assign raster_y_e = {1'b0, Y};
    assign count_inc  = count_reg + CNT_W'(1);

    // Paddle test uses the candidate X and the current (not yet updated) Y.
    assign pad_hit = (nx_e < pad_x_e + pad_w_e) && (pad_x_e < nx_e + SZ_W_E) &&
                     (py_e < pad_y_e + pad_h_e) && (pad_y_e < py_e + SZ_H_E);

    assign pix_hit = (raster_x_e >= px_e) && (raster_x_e < px_e + SZ_W_E) &&
                     (raster_y_e >= py_e) && (raster_y_e < py_e + SZ_H_E);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign rgb_mask[gi*4 +: 4] = pix_hit ? rgbIn[gi*4 +: 4] : 4'h0;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        pos_x_next     = pos_x_reg;
        pos_y_next     = pos_y_reg;
        dir_x_neg_next = dir_x_neg_reg;
        dir_y_neg_next = dir_y_neg_reg;
        lives_next     = lives_reg;
        count_next     = count_reg;

        case (state_reg)
            ST_IDLE: begin
                pos_x_next     = START_X_C;
                pos_y_next     = START_Y_C;
                dir_x_neg_next = 1'b0;
                dir_y_neg_next = 1'b0;
                count_next     = '0;
                if (launch) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                pos_x_next = START_X_C;
                pos_y_next = START_Y_C;
                if (tick) begin
                    count_next = count_inc;
                    if (count_inc == WAIT_C) begin
                        state_next = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (tick) begin
                    if (delX != '0) begin
                        if (dir_x_neg_reg) begin
                            if (px_e < dx_e) begin
                                pos_x_next     = '0;
                                dir_x_neg_next = 1'b0;
                            end else begin
                                pos_x_next = pos_x_reg - CW'(delX);
                            end
                        end else if (pad_hit) begin
                            pos_x_next     = padX - SZ_W_C;
                            dir_x_neg_next = 1'b1;
                        end else if (nx_e + SZ_W_E > SCR_W_E) begin
                            state_next = ST_MISS;
                        end else begin
                            pos_x_next = pos_x_reg + CW'(delX);
                        end
                    end
                    // A miss freezes the ball where it was; Y is left alone that tick.
                    if (state_next != ST_MISS && delY != '0) begin
                        if (dir_y_neg_reg) begin
                            if (py_e < dy_e) begin
                                pos_y_next     = '0;
                                dir_y_neg_next = 1'b0;
                            end else begin
                                pos_y_next = pos_y_reg - CW'(delY);
                            end
                        end else if (py_e + dy_e + SZ_H_E >= SCR_H_E) begin
                            pos_y_next     = BOTTOM_C;
                            dir_y_neg_next = 1'b1;
                        end else begin
                            pos_y_next = pos_y_reg + CW'(delY);
                        end
                    end
                end
            end
            ST_MISS: begin
                lives_next     = lives_reg - 4'd1;
                pos_x_next     = START_X_C;
                pos_y_next     = START_Y_C;
                dir_x_neg_next = 1'b0;
                dir_y_neg_next = 1'b0;
                count_next     = '0;
                state_next     = (lives_reg <= 4'd1) ? ST_OVER : ST_SERVE;
            end
            ST_OVER: begin
                if (launch) begin
                    lives_next = LIVES_C;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= ST_IDLE;
            pos_x_reg     <= START_X_C;
            pos_y_reg     <= START_Y_C;
            dir_x_neg_reg <= 1'b0;
            dir_y_neg_reg <= 1'b0;
            lives_reg     <= LIVES_C;
            count_reg     <= '0;
            yes_reg       <= 1'b0;
            rgb_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pos_x_reg     <= pos_x_next;
            pos_y_reg     <= pos_y_next;
            dir_x_neg_reg <= dir_x_neg_next;
            dir_y_neg_reg <= dir_y_neg_next;
            lives_reg     <= lives_next;
            count_reg     <= count_next;
            yes_reg       <= pix_hit;
            rgb_reg       <= rgb_mask;
        end
    end

    assign yes       = yes_reg;
    assign red       = rgb_reg[11:8];
    assign green     = rgb_reg[7:4];
    assign blue      = rgb_reg[3:0];
    assign posX      = pos_x_reg;
    assign posY      = pos_y_reg;
    assign miss      = (state_reg == ST_MISS);
    assign livesLeft = lives_reg;
    assign gameOver  = (state_reg == ST_OVER);

endmodule

// File: tb/tb_bounce_sprite.sv
// Directed bench for bounce_sprite: a table of per-tick motion vectors, a pixel table,
// and hand-written reset, serve and miss/game-over sequences.
module tb_bounce_sprite;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [10:0] x_pix, y_pix;
    logic [4:0]  del_x, del_y;
    logic [11:0] rgb_in;
    logic        launch;
    logic [10:0] pad_x, pad_y, pad_w, pad_h;
    logic        yes;
    logic [3:0]  red, green, blue;
    logic [10:0] pos_x, pos_y;
    logic        miss;
    logic [3:0]  lives_left;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    bounce_sprite #(.SERVE_WAIT(4)) dut (
        .CLK_100MHz(clk), .Reset(rst_n), .tick(tick), .X(x_pix), .Y(y_pix),
        .delX(del_x), .delY(del_y), .rgbIn(rgb_in), .launch(launch),
        .padX(pad_x), .padY(pad_y), .padW(pad_w), .padH(pad_h),
        .yes(yes), .red(red), .green(green), .blue(blue),
        .posX(pos_x), .posY(pos_y), .miss(miss), .livesLeft(lives_left), .gameOver(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int reps;
        int dx, dy;
        int px, py, pw, ph;
        int ex, ey;
    } vec_t;

    typedef struct {
        int x, y;
        int ey;
    } pix_t;

    vec_t vq[$];
    pix_t pq[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pad_away();
        pad_x = 11'd700; pad_y = 11'd700; pad_w = 11'd20; pad_h = 11'd10;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; launch = 1'b0;
        x_pix = 11'd1000; y_pix = 11'd1000; rgb_in = 12'hABC;
        del_x = 5'd6; del_y = 5'd4;
        pad_away();

        // motion table starting from a fresh serve at (0,0), both directions positive
        vq.push_back('{1,  6,  4, 700, 700, 20,  10,   6,   4});
        vq.push_back('{1,  0,  0, 700, 700, 20,  10,   6,   4});
        vq.push_back('{1, 10,  4,  29,   0,  5,  10,  15,   8});
        vq.push_back('{1,  6,  0, 700, 700, 20,  10,   9,   8});
        vq.push_back('{1,  6,  0, 700, 700, 20,  10,   3,   8});
        vq.push_back('{18, 0, 31, 700, 700, 20,  10,   3, 566});
        vq.push_back('{1,  0, 12, 700, 700, 20,  10,   3, 578});
        vq.push_back('{1,  6,  4, 700, 700, 20,  10,   0, 580});
        vq.push_back('{1,  6,  4, 700, 700, 20,  10,   6, 576});
        vq.push_back('{10, 31, 31, 700, 700, 20, 10, 316, 266});
        vq.push_back('{12, 31, 0, 700, 700, 20,  10, 688, 266});
        vq.push_back('{1, 31,  6, 700, 700, 20,  10, 719, 260});
        vq.push_back('{1,  1,  0, 700, 700, 20,  10, 720, 260});
        vq.push_back('{1,  6,  0, 739, 249, 20, 100, 725, 260});
        vq.push_back('{1,  6,  0, 700, 700, 20,  10, 719, 260});
        vq.push_back('{8,  0, 31, 700, 700, 20,  10, 719,  12});
        vq.push_back('{1,  0, 20, 700, 700, 20,  10, 719,   0});
        vq.push_back('{1,  0,  5, 700, 700, 20,  10, 719,   5});

        // raster probes around the sprite parked at (719,5), 14x20
        pq.push_back('{719,  5, 1});
        pq.push_back('{732, 24, 1});
        pq.push_back('{733,  5, 0});
        pq.push_back('{718,  5, 0});
        pq.push_back('{719, 25, 0});
        pq.push_back('{719,  4, 0});
        pq.push_back('{725, 15, 1});

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_posX", int'(pos_x), 0);
        check("rst_posY", int'(pos_y), 0);
        check("rst_lives", int'(lives_left), 3);
        check("rst_yes", int'(yes), 0);
        check("rst_rgb", int'({red, green, blue}), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_over", int'(game_over), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // serve: four ticks at START, then moving
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            check("serve_hold_x", int'(pos_x), 0);
        end
        $display("serve complete pos=(%0d,%0d)", pos_x, pos_y);

        foreach (vq[i]) begin
            del_x = 5'(vq[i].dx); del_y = 5'(vq[i].dy);
            pad_x = 11'(vq[i].px); pad_y = 11'(vq[i].py);
            pad_w = 11'(vq[i].pw); pad_h = 11'(vq[i].ph);
            for (int r = 0; r < vq[i].reps; r++) do_tick();
            $display("vec %0d pos=(%0d,%0d) want=(%0d,%0d)", i, pos_x, pos_y, vq[i].ex, vq[i].ey);
            check($sformatf("vec%0d_posX", i), int'(pos_x), vq[i].ex);
            check($sformatf("vec%0d_posY", i), int'(pos_y), vq[i].ey);
            check($sformatf("vec%0d_miss", i), int'(miss), 0);
        end
        pad_away();

        foreach (pq[i]) begin
            x_pix = 11'(pq[i].x); y_pix = 11'(pq[i].y);
            @(negedge clk);
            $display("pix %0d (%0d,%0d) yes=%0d rgb=%03h", i, pq[i].x, pq[i].y, yes, {red, green, blue});
            check($sformatf("pix%0d_yes", i), int'(yes), pq[i].ey);
            check($sformatf("pix%0d_rgb", i), int'({red, green, blue}), (pq[i].ey != 0) ? 'hABC : 0);
        end

        // asynchronous reset mid-move while the last pixel probe is a hit
        #2 rst_n = 1'b0;
        #1;
        $display("async reset pos=(%0d,%0d) yes=%0d", pos_x, pos_y, yes);
        check("arst_posX", int'(pos_x), 0);
        check("arst_posY", int'(pos_y), 0);
        check("arst_lives", int'(lives_left), 3);
        check("arst_yes", int'(yes), 0);
        check("arst_rgb", int'({red, green, blue}), 0);
        x_pix = 11'd1000; y_pix = 11'd1000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores ticks; launch together with a tick does not count that tick
        del_x = 5'd31; del_y = 5'd0;
        pad_x = 11'd900; pad_y = 11'd0; pad_w = 11'd1; pad_h = 11'd1;
        do_tick();
        check("idle_posX", int'(pos_x), 0);
        launch = 1'b1;
        do_tick();
        launch = 1'b0;

        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 4; i++) do_tick();
            check($sformatf("r%0d_serve_x", rnd), int'(pos_x), 0);
            for (int i = 0; i < 25; i++) do_tick();
            check($sformatf("r%0d_pre_x", rnd), int'(pos_x), 775);
            check($sformatf("r%0d_pre_miss", rnd), int'(miss), 0);
            do_tick();
            check($sformatf("r%0d_miss", rnd), int'(miss), 1);
            check($sformatf("r%0d_miss_x", rnd), int'(pos_x), 775);
            check($sformatf("r%0d_miss_lives", rnd), int'(lives_left), 3 - rnd);
            @(negedge clk);
            $display("round %0d miss=%0d lives=%0d over=%0d pos=(%0d,%0d)",
                     rnd, miss, lives_left, game_over, pos_x, pos_y);
            check($sformatf("r%0d_post_miss", rnd), int'(miss), 0);
            check($sformatf("r%0d_lives", rnd), int'(lives_left), 2 - rnd);
            check($sformatf("r%0d_start_x", rnd), int'(pos_x), 0);
            check($sformatf("r%0d_over", rnd), int'(game_over), (rnd == 2) ? 1 : 0);
        end

        // OVER: frozen position, pixel path still live, launch reloads lives
        do_tick();
        check("over_frozen_x", int'(pos_x), 0);
        check("over_flag", int'(game_over), 1);
        x_pix = 11'd0; y_pix = 11'd0;
        @(negedge clk);
        check("over_pix_yes", int'(yes), 1);
        check("over_pix_rgb", int'({red, green, blue}), 'hABC);
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        $display("relaunch lives=%0d over=%0d", lives_left, game_over);
        check("relaunch_lives", int'(lives_left), 3);
        check("relaunch_over", int'(game_over), 0);
        do_tick();
        check("relaunch_idle_x", int'(pos_x), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
